pipe_skid_reg: RTL
==================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the payload bit width (WIDTH >= 1).
REQ-002 The block SHALL take parameter BUBBLE, default {WIDTH{1'b0}}, as the payload value loaded on reset/flush.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port flush  input  1  synchronous pipeline flush, from the hazard unit.
REQ-006 The block SHALL have port in_valid  input  1  upstream stage holds a valid payload.
REQ-007 The block SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 The block SHALL have port in_ready  output  1  block can accept a payload this cycle.
REQ-009 The block SHALL have port out_valid  output  1  out_data holds a valid payload.
REQ-010 The block SHALL have port out_data  output  WIDTH  downstream payload.
REQ-011 The block SHALL have port out_ready  input  1  downstream stage accepts out_data this cycle.
REQ-012 The block SHALL have port occupancy  output  2  entries held: 0, 1 or 2.
REQ-013 The block SHALL have port stall_cnt  output  16  saturating count of back-pressure cycles.

Function
REQ-014 The block SHALL hold two WIDTH-bit registers, MAIN (drives out_data) and SKID, and a state register EMPTY/ONE/FULL.
REQ-015 The block SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-016 The block SHALL drive in_ready = (state != FULL) & ~reset & ~flush, combinationally, with no dependence on out_ready.
REQ-017 The block SHALL drive out_valid = (state != EMPTY), occupancy = 0/1/2 for EMPTY/ONE/FULL, and out_data = MAIN.
REQ-018 EMPTY: in_fire -> MAIN<=in_data, go to ONE; otherwise stay EMPTY.
REQ-019 ONE: in_fire & out_fire -> MAIN<=in_data, stay ONE; in_fire only -> SKID<=in_data, go to FULL; out_fire only -> go to EMPTY; neither -> hold.
REQ-020 FULL: out_fire -> MAIN<=SKID, go to ONE; otherwise hold (in_fire impossible).
REQ-021 Latency SHALL be exactly 1 cycle from in_fire to out_valid when EMPTY; sustained throughput SHALL be 1 payload/cycle with out_ready held high.
REQ-022 While out_valid=1 and out_ready=0, out_data SHALL remain stable; payloads SHALL leave in arrival order with none lost or duplicated.
REQ-023 flush=1 SHALL, at the next edge, force state EMPTY and MAIN=SKID=BUBBLE, discarding held payloads and any same-cycle in_valid.
REQ-024 flush SHALL take priority over every handshake; reset SHALL take priority over flush.
REQ-025 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 and out_ready=0, saturate at 16'hFFFF, and be unaffected by flush.

Reset
REQ-026 reset=1 SHALL, at the next edge, set state EMPTY, MAIN=SKID=BUBBLE, and stall_cnt=0.
REQ-027 After reset: out_valid=0, occupancy=0, out_data=BUBBLE, stall_cnt=0; in_ready=1 from the first cycle reset is low.
REQ-028 Reset asserted mid-operation SHALL drop all held payloads, with no partial update of any register.

Verification
REQ-029 Streaming: reset, then in_valid=1 and out_ready=1 with data 1,2,3,4 -> out_data 1,2,3,4 one cycle later each, occupancy=1 throughout, stall_cnt=0.
REQ-030 Back-pressure: out_ready=0, push A then B -> occupancy 1 then 2, in_ready=0, out_data=A held; raise out_ready -> A then B out, occupancy 1 then 0.
REQ-031 Flush: FULL with A,B and flush=1 while in_valid=1 (C) -> next cycle out_valid=0, occupancy=0, out_data=BUBBLE; C never appears.
REQ-032 Simultaneous: in ONE with A held, in_fire(B) and out_fire same cycle -> A consumed, out_data=B next cycle, occupancy stays 1.
REQ-033 Saturation: out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF, no wrap; a flush leaves it unchanged; reset clears it to 0.
REQ-034 Mid-op reset: FULL, then reset=1 for 1 cycle with out_ready=1 -> no payload emitted, occupancy=0, out_data=BUBBLE.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//
// Two-entry skid-buffered pipeline register. It breaks the combinational
// path on the ready signal, so in_ready depends only on local state and
// reset/flush, never on out_ready. It still sustains one payload per cycle
// when the downstream stage is always ready.
//
// Storage:
//   main  - the entry presented downstream (drives out_data)
//   skid  - catches the payload accepted in the cycle when the downstream
//           stage stalls while main is already occupied
//   state - EMPTY / ONE / FULL (number of valid entries)
//
// Parameters:
//   WIDTH   payload width in bits (>= 1)
//   BUBBLE  payload value loaded into main/skid on reset or flush
//
// Ports:
//   clk        in   single clock, all state updates on the rising edge
//   reset      in   synchronous, active-high; highest priority
//   flush      in   synchronous pipeline flush; beats every handshake
//   in_valid   in   upstream holds a valid payload
//   in_data    in   upstream payload
//   in_ready   out  block accepts a payload this cycle
//   out_valid  out  out_data holds a valid payload
//   out_data   out  downstream payload (the main register)
//   out_ready  in   downstream accepts out_data this cycle
//   occupancy  out  entries held: 0, 1 or 2
//   stall_cnt  out  saturating count of cycles with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int                WIDTH  = 32,
    parameter logic [WIDTH-1:0]  BUBBLE = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  main_q,  main_d;
    logic [WIDTH-1:0]  skid_q,  skid_d;
    logic [15:0]       stall_q;

    logic              in_fire;
    logic              out_fire;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    // in_ready is derived from registered state only (plus reset/flush), so
    // the upstream stage never sees a combinational path from out_ready.
    // Deasserting it during reset/flush keeps upstream from believing a
    // payload was taken when it is about to be discarded.
    assign in_ready  = (state_q != FULL) & ~reset & ~flush;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign stall_cnt = stall_q;

    assign in_fire   = in_valid  & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        case (state_q)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state / datapath
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a missing
        // assignment on any path would otherwise infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end

            ONE: begin
                if (in_fire && out_fire) begin
                    // Current head leaves while the new payload lands
                    // directly in main: occupancy unchanged.
                    main_d = in_data;
                end else if (in_fire) begin
                    // Downstream stalled: park the new payload in skid so
                    // main (and therefore out_data) stays stable.
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_fire) begin
                    // main keeps the consumed value; it is simply no longer
                    // flagged valid.
                    state_d = EMPTY;
                end
            end

            FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end

            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and payload registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the payload registers are reset (not just the state)
            // because out_data is visible and must read BUBBLE afterwards.
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else if (flush) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Back-pressure counter
    // -----------------------------------------------------------------------
    // Counts cycles where a valid payload is refused downstream. It is a
    // performance statistic, so flush does not touch it; only reset clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else if (out_valid && !out_ready && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

endmodule
